// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// mult/multu use shift-add and div/divu use restoring division; both take 32 RUN cycles plus one FIX cycle.
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] inA,
  input  logic [31:0] inB,
  input  logic        wen_hi,
  input  logic        wen_lo,
  input  logic [31:0] wd,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic        is_div;
  logic        sign_a;
  logic        sign_b;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [63:0] acc;

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] x);
    return ~x + 64'd1;
  endfunction

  function automatic logic [31:0] abs32(input logic signed [31:0] x);
    return (x < 0) ? neg32(x) : x;
  endfunction

  logic        signed_op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [32:0] mul_sum;
  logic [32:0] rem_sh;
  logic [32:0] trial;
  logic        divz;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  assign signed_op = ~op[0];
  assign a_in      = signed_op ? abs32(inA) : inA;
  assign b_in      = signed_op ? abs32(inB) : inB;

  // acc[63:32] is the running partial product / remainder, acc[31:0] the multiplier / dividend-quotient.
  assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, a_mag} : 33'd0);
  assign rem_sh  = {acc[63:32], acc[31]};
  assign trial   = rem_sh - {1'b0, b_mag};

  // With a zero divisor the remainder is the dividend magnitude, so the usual sign fix restores inA in HI.
  assign divz     = (b_mag == 32'd0);
  assign prod_fix = (sign_a ^ sign_b) ? neg64(acc) : acc;
  assign quo_fix  = divz ? 32'hFFFFFFFF :
                    ((sign_a ^ sign_b) ? neg32(acc[31:0]) : acc[31:0]);
  assign rem_fix  = sign_a ? neg32(acc[63:32]) : acc[63:32];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      is_div <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      a_mag  <= 32'd0;
      b_mag  <= 32'd0;
      acc    <= 64'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= 32'd0;
      lo     <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div <= op[1];
            sign_a <= signed_op & inA[31];
            sign_b <= signed_op & inB[31];
            a_mag  <= a_in;
            b_mag  <= b_in;
            acc    <= op[1] ? {32'd0, a_in} : {32'd0, b_in};
            cnt    <= 5'd0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            if (wen_hi) hi <= wd;
            if (wen_lo) lo <= wd;
          end
        end
        RUN: begin
          if (is_div) begin
            acc <= trial[32] ? {rem_sh[31:0], acc[30:0], 1'b0}
                             : {trial[31:0], acc[30:0], 1'b1};
          end else begin
            acc <= {mul_sum, acc[31:1]};
          end
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[63:32];
            lo <= prod_fix[31:0];
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit multiply/divide unit with architectural HI/LO registers for the single-cycle/multicycle MIPS datapath. It sits directly downstream of the register file, beside the ALU, and consumes the register file read data as its two operands. It executes mult, multu, div and divu in a fixed 33-cycle sequence under a start/busy/done handshake. It also supports mthi/mtlo writes and continuous HI/LO reads for mfhi/mflo.

## Interface

Parameters: none; all datapaths are fixed at 32 bits.

- clk  input  1  system clock; all state changes on posedge
- reset  input  1  asynchronous, active-low reset
- start  input  1  request a new operation; sampled at posedge
- op  input  2  operation: 00 mult (signed), 01 multu, 10 div (signed), 11 divu
- inA  input  32  multiplicand or dividend (register file rdA)
- inB  input  32  multiplier or divisor (register file rdB)
- wen_hi  input  1  mthi write enable
- wen_lo  input  1  mtlo write enable
- wd  input  32  mthi/mtlo write data
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; HI/LO hold the new result
- hi  output  32  HI register (product[63:32] or remainder)
- lo  output  32  LO register (product[31:0] or quotient)

## Operation

- States: IDLE, RUN, FIX.
- **IDLE**
  - On start=1: capture op and the operand signs.
  - Load |inA| and |inB| for signed ops; load the raw values for unsigned ops.
  - Clear the 5-bit iteration counter and go to RUN.
- **RUN**
  - Performs one iteration per cycle for 32 cycles; leaves for FIX when the counter reaches 31.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring division with a 33-bit partial remainder; the quotient bit is 1 when the trial subtraction is non-negative.
- **FIX** (one cycle)
  - Applies sign correction, writes HI/LO, pulses done, returns to IDLE.
- **Sign rules**
  - mult: negate the 64-bit product when signA ^ signB.
  - div: negate the quotient when signA ^ signB; negate the remainder when signA.
  - The remainder always takes the sign of the dividend.
- **Divide by zero** (div or divu): LO = 32'hFFFFFFFF, HI = inA as captured (original, not magnitude). Latency is unchanged.
- **Signed overflow** (div 32'h80000000 by 32'hFFFFFFFF): LO = 32'h80000000, HI = 0.
- **Start while busy:** ignored, with no queuing. The operands must be held by the datapath only at the accept edge.
- **mthi/mtlo**
  - At posedge in IDLE with start=0: wen_hi loads wd into HI, wen_lo loads wd into LO. Both may be asserted together.
  - Ignored when busy.
  - Ignored in the same cycle as an accepted start, because start wins.
- HI/LO are stable at all times except the FIX edge and mthi/mtlo edges.

## Timing

- **Reset** (asynchronous, active-low): state = IDLE, busy = 0, done = 0, hi = 0, lo = 0, counter = 0, accumulators = 0.
  - Takes effect immediately, including mid-operation; any operation in progress is abandoned with no done pulse.
- **Accept:** start=1 in IDLE at edge E0.
  - busy = 1 from E0 until E33.
  - RUN iterations occur at E1..E32; FIX occurs at E33.
- **Completion at E33:**
  - hi/lo take the final result.
  - done = 1 for exactly one cycle (E33 to E34).
  - busy = 0.
- Total latency: 33 cycles from the accept edge to result valid.
- **Back-to-back:** the earliest next accept is E33's following edge (E34), while done is high; done still drops at E34.
- done never asserts without a preceding accept, and never twice for one accept.
- Operands are sampled only at E0; changes on inA/inB/op during busy have no effect.

## Test plan

- **Reset:** assert reset mid-RUN.
  - busy, done, hi and lo go to 0 immediately (asynchronously).
  - After release there is no done pulse and the unit is idle.
- **multu:** 32'hFFFFFFFF x 32'hFFFFFFFF.
  - At E33: hi = 32'hFFFFFFFE, lo = 32'h00000001.
  - done is high for 1 cycle; busy is high for E0..E33.
- **mult:** 32'hFFFFFFFD (-3) x 7 gives hi = 32'hFFFFFFFF, lo = 32'hFFFFFFEB (-21).
- **div/divu**
  - div -7 / 2: lo = 32'hFFFFFFFD (-3), hi = 32'hFFFFFFFF (-1).
  - divu 100 / 7: lo = 14, hi = 2.
  - divu 5 / 0: lo = 32'hFFFFFFFF, hi = 5.
  - div 32'h80000000 / -1: lo = 32'h80000000, hi = 0.
- **Handshake**
  - start pulsed repeatedly during busy: ignored, exactly one done, result of the first operands only.
  - New start at E34 (with done high): accepted; its done arrives 33 cycles later.
- **mthi/mtlo**
  - In IDLE, wen_hi = wen_lo = 1 with wd = 32'hA5A5A5A5: hi = lo = 32'hA5A5A5A5 next cycle.
  - The same write during busy, or coincident with start: HI/LO are not modified by the write.
